// File: rtl/spidac_rx.sv
// spidac_rx: DAC-side receiver for a 3-wire SCLK/nCS/DIN link, oversampled on clk.
// Optional build macro SPIDAC_RX_SUBLSB_CHECK_EN rejects frames whose sub-LSB fill bits are non-zero.
module spidac_rx #(
    parameter int FRAME_BITS  = 12,
    parameter int DATA_BITS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 dac_sclk,
    input  logic                 DAC_nCS,
    input  logic                 dac_din,
    output logic [DATA_BITS-1:0] dac_code,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);

    localparam int FILL_BITS = FRAME_BITS - DATA_BITS;
    localparam int SETTLE    = SYNC_STAGES + 2;

    typedef enum logic [1:0] {
        ST_WAIT_HIGH = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] din_sync_r;
    logic                   sclk_s;
    logic                   ncs_s;
    logic                   din_s;
    logic                   sclk_d_r;
    logic                   ncs_d_r;
    logic                   din_d_r;
    logic                   sclk_rise_r;
    logic                   ncs_rise_r;
    logic                   ncs_fall_r;
    logic [2:0]             settle_cnt_r;
    logic                   settled_s;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [FRAME_BITS-1:0]  shift_reg_r;
    logic [4:0]             bit_cnt_r;
    logic                   clear_s;
    logic                   shift_en_s;
    logic                   eval_s;
    logic                   len_ok_s;
    logic                   fill_ok_s;
    logic                   accept_s;
    logic                   reject_s;

    logic                   accept_pend_r;
    logic                   reject_pend_r;
    logic [DATA_BITS-1:0]   code_pend_r;
    logic [DATA_BITS-1:0]   dac_code_r;
    logic                   code_valid_r;
    logic                   frame_err_r;
    logic                   busy_r;
    logic [7:0]             frame_cnt_r;

`ifdef SPIDAC_RX_SUBLSB_CHECK_EN
    function automatic logic fill_is_zero(input logic [FILL_BITS-1:0] fill);
        return (fill == {FILL_BITS{1'b0}});
    endfunction
`endif

    assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_r[SYNC_STAGES-1];
    assign din_s     = din_sync_r[SYNC_STAGES-1];
    assign settled_s = (settle_cnt_r == 3'(SETTLE));

    // Metastability synchronizers; nCS idles high so its chain resets to 1.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_sync_r  <= {SYNC_STAGES{1'b1}};
            din_sync_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], dac_sclk};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], DAC_nCS};
            din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], dac_din};
        end
    end

    // Edge-detect flops and registered edge strobes; din is delayed alongside sclk.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sclk_d_r    <= 1'b0;
            ncs_d_r     <= 1'b1;
            din_d_r     <= 1'b0;
            sclk_rise_r <= 1'b0;
            ncs_rise_r  <= 1'b0;
            ncs_fall_r  <= 1'b0;
        end else begin
            sclk_d_r    <= sclk_s;
            ncs_d_r     <= ncs_s;
            din_d_r     <= din_s;
            sclk_rise_r <= sclk_s & ~sclk_d_r;
            ncs_rise_r  <= ncs_s & ~ncs_d_r;
            ncs_fall_r  <= ~ncs_s & ncs_d_r;
        end
    end

    // Holds WAIT_HIGH until the pipeline carries real pin samples, not reset values.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            settle_cnt_r <= 3'd0;
        end else if (!settled_s) begin
            settle_cnt_r <= settle_cnt_r + 3'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_WAIT_HIGH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT_HIGH: begin
                if (settled_s && ncs_d_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HIGH;
                end
            end
            ST_IDLE: begin
                if (ncs_fall_r) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ncs_rise_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: state_next_s = ST_WAIT_HIGH;
        endcase
    end

    // FSM output decode; an sclk edge coinciding with either nCS edge is dropped.
    always_comb begin
        clear_s    = 1'b0;
        shift_en_s = 1'b0;
        eval_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = ncs_fall_r;
            end
            ST_ACTIVE: begin
                shift_en_s = sclk_rise_r & ~ncs_rise_r;
                eval_s     = ncs_rise_r;
            end
            default: begin
                clear_s    = 1'b0;
                shift_en_s = 1'b0;
                eval_s     = 1'b0;
            end
        endcase
    end

    assign len_ok_s = (bit_cnt_r == 5'(FRAME_BITS));
`ifdef SPIDAC_RX_SUBLSB_CHECK_EN
    assign fill_ok_s = fill_is_zero(shift_reg_r[FILL_BITS-1:0]);
`else
    assign fill_ok_s = 1'b1;
`endif
    assign accept_s = eval_s & len_ok_s & fill_ok_s;
    assign reject_s = eval_s & ~(len_ok_s & fill_ok_s);

    // Shift register and saturating bit counter.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            shift_reg_r <= {FRAME_BITS{1'b0}};
            bit_cnt_r   <= 5'd0;
        end else if (clear_s) begin
            shift_reg_r <= {FRAME_BITS{1'b0}};
            bit_cnt_r   <= 5'd0;
        end else if (shift_en_s) begin
            shift_reg_r <= {shift_reg_r[FRAME_BITS-2:0], din_d_r};
            bit_cnt_r   <= (bit_cnt_r == 5'd31) ? 5'd31 : (bit_cnt_r + 5'd1);
        end else begin
            shift_reg_r <= shift_reg_r;
            bit_cnt_r   <= bit_cnt_r;
        end
    end

    // Frame verdict stage.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            accept_pend_r <= 1'b0;
            reject_pend_r <= 1'b0;
            code_pend_r   <= {DATA_BITS{1'b0}};
        end else begin
            accept_pend_r <= accept_s;
            reject_pend_r <= reject_s;
            code_pend_r   <= shift_reg_r[FRAME_BITS-1 -: DATA_BITS];
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            dac_code_r   <= {DATA_BITS{1'b0}};
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            code_valid_r <= accept_pend_r;
            frame_err_r  <= reject_pend_r;
            busy_r       <= (state_next_s == ST_ACTIVE);
            if (accept_pend_r) begin
                dac_code_r  <= code_pend_r;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                dac_code_r  <= dac_code_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign dac_code   = dac_code_r;
    assign code_valid = code_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_spidac_rx.sv
// Randomized self-checking bench for spidac_rx against a frame-level reference model.
module tb_spidac_rx;

    localparam int FRAME_BITS  = 12;
    localparam int DATA_BITS   = 10;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sclk = 1'b0;
    logic                 ncs = 1'b1;
    logic                 din = 1'b0;
    logic [DATA_BITS-1:0] dac_code;
    logic                 code_valid;
    logic                 frame_err;
    logic                 busy;
    logic [7:0]           frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    int both_seen  = 0;

    int exp_valid = 0;
    int exp_err   = 0;
    int exp_code  = 0;
    int exp_cnt   = 0;

    spidac_rx #(
        .FRAME_BITS (FRAME_BITS),
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .Reset     (rst_n),
        .dac_sclk  (sclk),
        .DAC_nCS   (ncs),
        .dac_din   (din),
        .dac_code  (dac_code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling clk edge.
    always @(negedge clk) begin
        if (code_valid) valid_seen <= valid_seen + 1;
        if (frame_err) err_seen <= err_seen + 1;
        if (code_valid && frame_err) both_seen <= both_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame of n bits; optionally pulses Reset after rst_after bits.
    task automatic send_frame(input logic [31:0] v, input int n, input int rst_after,
                              output int lat, output logic busy_mid);
        logic [31:0] vv;
        vv  = v;
        ncs = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            din = vv[i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            if (rst_after == n - i) begin
                rst_n = 1'b0;
                wait_clk(3);
                rst_n = 1'b1;
            end
        end
        wait_clk(HALF);
        busy_mid = busy;
        ncs = 1'b1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (code_valid || frame_err)) lat = k;
        end
        wait_clk(8);
    endtask

    // Reference: a frame is accepted only with exactly FRAME_BITS bits (and, with the
    // fill check built, zero fill bits); the code is the top DATA_BITS of the frame.
    task automatic do_frame(input logic [31:0] v, input int n);
        int lat;
        logic bm;
        int fill;
        bit acc;
        fill = int'(v) % (1 << (FRAME_BITS - DATA_BITS));
        acc  = (n == FRAME_BITS);
`ifdef SPIDAC_RX_SUBLSB_CHECK_EN
        if (fill != 0) acc = 1'b0;
`endif
        send_frame(v, n, -1, lat, bm);
        if (acc) begin
            exp_valid++;
            exp_code = int'(v) / (1 << (FRAME_BITS - DATA_BITS));
            exp_cnt  = (exp_cnt + 1) % 256;
        end else begin
            exp_err++;
        end
        check("busy_in_frame", 32'(bm), 32'd1);
        check("pulse_latency", 32'(lat), 32'(SYNC_STAGES + 2));
        check("valid_pulses", 32'(valid_seen), 32'(exp_valid));
        check("err_pulses", 32'(err_seen), 32'(exp_err));
        check("dac_code", 32'(dac_code), 32'(exp_code));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int lat;
        logic bm;
        int n;
        logic [31:0] v;

        wait_clk(5);
        check("rst_dac_code", 32'(dac_code), 32'd0);
        check("rst_code_valid", 32'(code_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        wait_clk(10);

        do_frame(32'hFFC, 12);
        do_frame(32'h554, 12);
        do_frame(32'h2A8, 12);
        do_frame(32'h7FF, 11);
        do_frame(32'h1FFF, 13);
        do_frame(32'h0, 0);

        // Reset mid-frame: everything clears and the tail of the frame is ignored.
        send_frame(32'hABC, 12, 6, lat, bm);
        exp_code = 0;
        exp_cnt  = 0;
        check("rstmid_no_pulse", 32'(lat), 32'hFFFF_FFFF);
        check("rstmid_valid", 32'(valid_seen), 32'(exp_valid));
        check("rstmid_err", 32'(err_seen), 32'(exp_err));
        check("rstmid_code", 32'(dac_code), 32'd0);
        check("rstmid_cnt", 32'(frame_cnt), 32'd0);

        do_frame(32'hFFC, 12);
        do_frame(32'hFFD, 12);

        // Link activity with nCS high must be ignored.
        for (int i = 0; i < 10; i++) begin
            din  = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        wait_clk(10);
        check("idle_valid", 32'(valid_seen), 32'(exp_valid));
        check("idle_err", 32'(err_seen), 32'(exp_err));

        // Enough legal frames to wrap frame_cnt, with occasional bad lengths mixed in.
        for (int i = 0; i < 260; i++) begin
            v = 32'($urandom) & 32'hFFF;
            do_frame(v, 12);
            if (i % 32 == 5) begin
                n = int'($urandom_range(1, 16));
                if (n == FRAME_BITS) n = 13;
                v = 32'($urandom) & ((32'h1 << n) - 32'h1);
                do_frame(v, n);
            end
        end

        check("never_both", 32'(both_seen), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
